// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled step enable driving eight selectable N-bit patterns.
// A mode change at a step edge loads that mode's seed value; otherwise the current mode advances one step.
module led_pattern_gen #(
   parameter int N   = 8,
   parameter int DIV = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [2:0]   SW,
   output logic [N-1:0] LED,
   output logic         tick
);

   localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [N-1:0]  LSB_ONE  = {{(N-1){1'b0}}, 1'b1};
   localparam logic [N-1:0]  MSB_ONE  = {1'b1, {(N-1){1'b0}}};

   logic [CW-1:0] r_count;
   logic [2:0]    r_mode;
   logic [N-1:0]  r_led;
   logic [N-1:0]  r_gray_cnt;
   logic          r_dir;
   logic          r_tick;

   logic          w_step;
   logic [N-1:0]  w_led_nxt;
   logic [N-1:0]  w_gray_nxt;
   logic [N-1:0]  w_gray_inc;
   logic [2:0]    w_mode_nxt;
   logic          w_dir_nxt;

   assign w_step     = en && (r_count == CNT_LAST);
   assign w_gray_inc = r_gray_cnt + LSB_ONE;

   // Prescaler: counts enabled cycles and wraps at the step edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (w_step) begin
         r_count <= '0;
      end else if (en) begin
         r_count <= r_count + CNT_ONE;
      end else begin
         r_count <= r_count;
      end
   end

   // Next pattern state: seed on mode change, else one step of the held mode (r_dir=0 means moving left).
   always_comb begin
      w_led_nxt  = r_led;
      w_mode_nxt = r_mode;
      w_dir_nxt  = r_dir;
      w_gray_nxt = r_gray_cnt;
      if (w_step) begin
         if (SW != r_mode) begin
            w_mode_nxt = SW;
            w_dir_nxt  = 1'b0;
            w_gray_nxt = '0;
            case (SW)
               3'd1:    w_led_nxt = LSB_ONE;
               3'd2:    w_led_nxt = MSB_ONE;
               3'd3:    w_led_nxt = LSB_ONE;
               default: w_led_nxt = '0;
            endcase
         end else begin
            case (r_mode)
               3'd0: w_led_nxt = '0;
               3'd1: w_led_nxt = {r_led[N-2:0], r_led[N-1]};
               3'd2: w_led_nxt = {r_led[0], r_led[N-1:1]};
               3'd3: begin
                  // Turn around at either end so the endpoint is not repeated.
                  if (!r_dir) begin
                     if (r_led[N-1]) begin
                        w_led_nxt = {1'b0, r_led[N-1:1]};
                        w_dir_nxt = 1'b1;
                     end else begin
                        w_led_nxt = {r_led[N-2:0], 1'b0};
                        w_dir_nxt = 1'b0;
                     end
                  end else begin
                     if (r_led[0]) begin
                        w_led_nxt = {r_led[N-2:0], 1'b0};
                        w_dir_nxt = 1'b0;
                     end else begin
                        w_led_nxt = {1'b0, r_led[N-1:1]};
                        w_dir_nxt = 1'b1;
                     end
                  end
               end
               3'd4: w_led_nxt = r_led + LSB_ONE;
               3'd5: w_led_nxt = (&r_led) ? '0 : {r_led[N-2:0], 1'b1};
               3'd6: w_led_nxt = ~r_led;
               3'd7: begin
                  w_gray_nxt = w_gray_inc;
                  w_led_nxt  = w_gray_inc ^ {1'b0, w_gray_inc[N-1:1]};
               end
               default: w_led_nxt = '0;
            endcase
         end
      end else begin
         w_led_nxt  = r_led;
         w_mode_nxt = r_mode;
      end
   end

   // Pattern state registers and the step pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_led      <= '0;
         r_mode     <= 3'd0;
         r_dir      <= 1'b0;
         r_gray_cnt <= '0;
         r_tick     <= 1'b0;
      end else begin
         r_led      <= w_led_nxt;
         r_mode     <= w_mode_nxt;
         r_dir      <= w_dir_nxt;
         r_gray_cnt <= w_gray_nxt;
         r_tick     <= w_step;
      end
   end

   assign LED  = r_led;
   assign tick = r_tick;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen (N=8, DIV=4): walks every mode and checks the en freeze and reset behaviour.
module tb_led_pattern_gen;

   logic       clk;
   logic       rst;
   logic       en;
   logic [2:0] SW;
   logic [7:0] LED;
   logic       tick;

   int n_checks = 0;
   int n_pass   = 0;

   led_pattern_gen #(.N(8), .DIV(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .SW   (SW),
      .LED  (LED),
      .tick (tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, required 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance until a tick is seen (bounded); n returns the number of edges taken.
   task automatic wait_tick(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!tick && n < 16);
      if (!tick) check("tick_timeout", 32'd0, 32'd1);
   endtask

   task automatic expect_seq(input string tag, input logic [7:0] vals[$]);
      int n;
      foreach (vals[i]) begin
         wait_tick(n);
         check({tag, "_led"}, LED, vals[i]);
         if (i > 0) check({tag, "_period"}, n, 32'd4);
      end
   endtask

   initial begin
      int n;
      logic [7:0] q[$];

      rst = 1'b0;
      en  = 1'b1;
      SW  = 3'd0;
      #1;
      check("rst_led", LED, 8'h00);
      check("rst_tick", tick, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_hold_led", LED, 8'h00);
      rst = 1'b1;

      // Mode 0: ticks on edges 4, 8 and 12 after release, LED stays dark.
      for (int e = 1; e <= 12; e++) begin
         @(posedge clk);
         #1;
         check("m0_tick", tick, (e % 4 == 0) ? 1'b1 : 1'b0);
         check("m0_led", LED, 8'h00);
      end

      SW = 3'd1;
      q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
      expect_seq("m1", q);

      SW = 3'd2;
      q = '{8'h80, 8'h40};
      expect_seq("m2", q);

      SW = 3'd3;
      q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
            8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
      expect_seq("m3", q);

      SW = 3'd4;
      q = {};
      for (int i = 0; i <= 256; i++) q.push_back(8'(i));
      expect_seq("m4", q);

      SW = 3'd7;
      q = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04, 8'h0C};
      expect_seq("m7", q);

      SW = 3'd5;
      q = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00, 8'h01, 8'h03};
      expect_seq("m5", q);

      SW = 3'd6;
      q = '{8'h00, 8'hFF, 8'h00};
      expect_seq("m6", q);

      // Freeze two edges into an interval, then resume with two edges left.
      repeat (2) begin
         @(posedge clk);
         #1;
         check("pre_freeze_tick", tick, 1'b0);
      end
      en = 1'b0;
      for (int e = 0; e < 10; e++) begin
         @(posedge clk);
         #1;
         check("freeze_led", LED, 8'h00);
         check("freeze_tick", tick, 1'b0);
      end
      en = 1'b1;
      wait_tick(n);
      check("resume_edges", n, 32'd2);
      check("resume_led", LED, 8'hFF);

      // Asynchronous reset between edges while tick is high and LED lit.
      SW = 3'd1;
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_led", LED, 8'h00);
      check("async_rst_tick", tick, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      wait_tick(n);
      check("post_rst_edges", n, 32'd4);
      check("post_rst_led", LED, 8'h01);
      wait_tick(n);
      check("post_rst_step", LED, 8'h02);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 SHALL have parameter N, default 8, LED count / pattern width; legal N >= 2.
REQ-002 SHALL have parameter DIV, default 4, clock cycles per pattern step; legal DIV >= 1.
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  step enable; low freezes prescaler and pattern.
REQ-006 SHALL have port SW  input  3  pattern mode select.
REQ-007 SHALL have port LED  output  N  registered pattern output.
REQ-008 SHALL have port tick  output  1  registered one-cycle pulse, high in the cycle LED takes a new value.

Function
REQ-009 SHALL hold prescaler count 0..DIV-1; incremented only when en=1.
REQ-010 SHALL, at an edge with en=1 and count=DIV-1, set count to 0, set tick=1, and update LED (a "step edge").
REQ-011 SHALL drive tick=0 after every edge that is not a step edge; DIV=1 with en=1 gives tick=1 continuously.
REQ-012 SHALL hold mode_q (3 bits); SW SHALL be sampled only at step edges.
REQ-013 SHALL, at a step edge with SW != mode_q, load mode_q<=SW and LED<=seed(SW), with no pattern step.
REQ-014 SHALL, at a step edge with SW == mode_q, apply one step of mode_q.
REQ-015 Mode 0 (off): seed 0; step keeps 0.
REQ-016 Mode 1 (run left): seed bit0 set; step rotates left, bit N-1 wraps to bit0.
REQ-017 Mode 2 (run right): seed bit N-1 set; step rotates right, bit0 wraps to bit N-1.
REQ-018 Mode 3 (ping-pong): seed bit0, dir=left; single lit bit moves one place per step; at bit N-1 dir flips and next step gives bit N-2; at bit0 dir flips and next step gives bit1; no bit is repeated at either end.
REQ-019 Mode 4 (binary count): seed 0; step LED+1 modulo 2^N, all-ones wraps to 0.
REQ-020 Mode 5 (fill bar): seed 0; step shifts left inserting 1 at bit0; from all-ones next step is 0.
REQ-021 Mode 6 (blink): seed 0; step inverts all bits.
REQ-022 Mode 7 (Gray count): internal N-bit counter seeded 0; step increments it modulo 2^N; LED = cnt XOR (cnt>>1) of the new value.
REQ-023 SHALL leave LED, mode_q, dir, Gray counter unchanged on any edge that is not a step edge.
REQ-024 SHALL, with en low mid-interval, hold count; on en returning high, counting resumes from held value.

Reset
REQ-025 SHALL, on rst=0, immediately (without clk) force count=0, mode_q=0, LED=0, tick=0, dir=left, Gray counter=0.
REQ-026 SHALL, after rst rises with en=1, produce the first step edge on the DIV-th rising clk edge.
REQ-027 SHALL, on reset asserted mid-pattern, discard all progress; the next mode load follows REQ-013.

Verification (N=8, DIV=4, en=1 unless stated)
REQ-028 rst=0 for 3 cycles then 1, SW=0 -> LED=0x00 throughout; tick high on edges 4, 8, 12 after release.
REQ-029 SW=1 -> ticks give 0x01 (load), 0x02, 0x04 ... 0x80, 0x01; then SW=2 -> next tick 0x80, then 0x40.
REQ-030 SW=3 -> 0x01, 0x02 ... 0x80, 0x40 ... 0x01, 0x02; endpoints each appear once per sweep.
REQ-031 SW=4 -> 0x00, 0x01 ... 0xFF, 0x00; SW=7 -> 0x00, 0x01, 0x03, 0x02, 0x06, 0x07, 0x05, 0x04.
REQ-032 SW=5 -> 0x00, 0x01, 0x03 ... 0xFF, 0x00; switch SW to 6 mid-run -> next tick 0x00, then 0xFF, 0x00.
REQ-033 en=0 for 10 cycles mid-interval -> LED and tick frozen, resumes with remaining count; rst pulsed low between edges -> LED=0x00 before next clk edge.
